// File: rtl/pool_pkg.sv
// pool_pkg: shared types and constants for the 2x2 pooling window generator.
package pool_pkg;
    typedef enum logic {ST_TOP, ST_BOT} pool_state_e;
    localparam int lpWIN = 4;
endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: register-array line buffer holding one row of pixel pairs.
module pool_line_buf #(
    parameter int pDEPTH = 16,
    parameter int pWIDTH = 16,
    parameter int pAW    = 4
) (
    input  logic              iclk,
    input  logic              iwe,
    input  logic [pAW-1:0]    iwaddr,
    input  logic [pWIDTH-1:0] iwdata,
    input  logic [pAW-1:0]    iraddr,
    output logic [pWIDTH-1:0] ordata
);
    logic [pWIDTH-1:0] mem [pDEPTH];

    always_ff @(posedge iclk)
        if (iwe) mem[iwaddr] <= iwdata;

    assign ordata = mem[iraddr];
endmodule

// File: rtl/pool2x2_window_gen.sv
// pool2x2_window_gen: streams a raster feature map and emits 2x2/stride-2 windows.
module pool2x2_window_gen
    import pool_pkg::*;
#(
    parameter int pDATA_W = 8,
    parameter int pIMG_W  = 32,
    parameter int pIMG_H  = 32
) (
    input  logic                         iclk,
    input  logic                         irst_n,
    input  logic                         iclr,
    input  logic                         ien,
    input  logic [pDATA_W-1:0]           idata,
    output logic [lpWIN-1:0][pDATA_W-1:0] odata,
    output logic                         oen,
    output logic                         oframe_done
);
    localparam int lpCW = $clog2(pIMG_W);
    localparam int lpRW = $clog2(pIMG_H);
    localparam int lpAW = pIMG_W > 2 ? $clog2(pIMG_W / 2) : 1;

    typedef logic [lpWIN-1:0][pDATA_W-1:0] pool_win_t;

    pool_state_e        state_q, state_n;
    logic [lpCW-1:0]    col;
    logic [lpRW-1:0]    row;
    logic [pDATA_W-1:0] prev_q;
    logic [2*pDATA_W-1:0] rdata;
    logic               acc, col_last, row_last, we, rd;
    logic [lpAW-1:0]    addr;
    pool_win_t          win_n;

    assign acc      = ien & ~iclr;
    assign col_last = col == lpCW'(pIMG_W - 1);
    assign row_last = row == lpRW'(pIMG_H - 1);
    assign we       = acc & (state_q == ST_TOP) & col[0];
    assign rd       = acc & (state_q == ST_BOT) & col[0];
    assign addr     = lpAW'(col >> 1);
    // Top row pair is stored as {TL, TR}; window packs BR in [3] down to TL in [0].
    assign win_n    = {idata, prev_q, rdata[pDATA_W-1:0], rdata[2*pDATA_W-1:pDATA_W]};

    pool_line_buf #(
        .pDEPTH(pIMG_W / 2),
        .pWIDTH(2 * pDATA_W),
        .pAW   (lpAW)
    ) u_line_buf (
        .iclk  (iclk),
        .iwe   (we),
        .iwaddr(addr),
        .iwdata({prev_q, idata}),
        .iraddr(addr),
        .ordata(rdata)
    );

    always_comb begin
        state_n = state_q;
        if (iclr) state_n = ST_TOP;
        else if (acc && col_last) state_n = state_q == ST_TOP ? ST_BOT : ST_TOP;
    end

    always_ff @(posedge iclk or negedge irst_n)
        if (!irst_n) state_q <= ST_TOP;
        else state_q <= state_n;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            col         <= '0;
            row         <= '0;
            prev_q      <= '0;
            odata       <= '0;
            oen         <= 1'b0;
            oframe_done <= 1'b0;
        end else if (iclr) begin
            col         <= '0;
            row         <= '0;
            prev_q      <= '0;
            odata       <= '0;
            oen         <= 1'b0;
            oframe_done <= 1'b0;
        end else begin
            oen         <= rd;
            oframe_done <= rd & row_last & col_last;
            if (rd) odata <= win_n;
            if (acc) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col_last) row <= row_last ? '0 : row + 1'b1;
                if (!col[0]) prev_q <= idata;
            end
        end
    end
endmodule

// File: tb/tb_pool2x2_window_gen.sv
// tb_pool2x2_window_gen: randomized bench against an image-indexed window model.
module tb_pool2x2_window_gen;
    localparam int W = 4;
    localparam int H = 4;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic en = 1'b0;
    logic [D-1:0] data = '0;
    logic [3:0][D-1:0] odata;
    logic oen, oframe_done;

    int n_cmp = 0;
    int n_err = 0;
    int idx = 0;
    logic [D-1:0] img [H][W];
    logic [31:0] exp_odata = '0;
    logic exp_oen = 1'b0;
    logic exp_done = 1'b0;

    always #5 clk = ~clk;

    pool2x2_window_gen #(.pDATA_W(D), .pIMG_W(W), .pIMG_H(H)) dut (
        .iclk       (clk),
        .irst_n     (rst_n),
        .iclr       (clr),
        .ien        (en),
        .idata      (data),
        .odata      (odata),
        .oen        (oen),
        .oframe_done(oframe_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("oen", 32'(oen), 32'(exp_oen));
        chk("frame_done", 32'(oframe_done), 32'(exp_done));
        chk("odata", odata, exp_odata);
    endtask

    // One clock: drive, let the edge pass, advance the model, then compare.
    task automatic step(input logic e, input logic [D-1:0] d, input logic c);
        int r, k;
        en = e;
        data = d;
        clr = c;
        @(posedge clk);
        exp_oen = 1'b0;
        exp_done = 1'b0;
        if (c) begin
            idx = 0;
            exp_odata = '0;
        end else if (e) begin
            r = (idx / W) % H;
            k = idx % W;
            img[r][k] = d;
            if (r % 2 == 1 && k % 2 == 1) begin
                exp_oen = 1'b1;
                exp_odata = {d, img[r][k-1], img[r-1][k], img[r-1][k-1]};
                exp_done = (r == H - 1) && (k == W - 1);
            end
            idx = (idx + 1) % (W * H);
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        #1;
        idx = 0;
        exp_odata = '0;
        exp_oen = 1'b0;
        exp_done = 1'b0;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, D'(i), 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, D'(100 + i), 1'b0);
            step(1'b0, D'($urandom), 1'b0);
        end
        for (int i = 0; i < 6; i++) step(1'b1, D'(50 + i), 1'b0);
        #2;
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, D'(i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, D'(200 + i), 1'b0);
        step(1'b1, 8'd205, 1'b1);
        step(1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, D'(i), 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, D'($urandom), $urandom_range(0, 59) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
